// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;

   // Magnitude of a sign-extended 32-bit operand. When sgn=0 the value is
   // zero-extended by the caller, so it passes through unchanged. The most
   // negative operand maps to 2^(WIDTH-1), which still fits in WIDTH bits.
   function automatic logic [31:0] abs_mag(input logic [31:0] value, input logic sgn);
      abs_mag = (sgn && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One partial-product row: AND the multiplicand with a multiplier bit,
// shift it into position and add it to the running accumulator.
module mult_pp_row
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0]   i_mcand,
   input  logic               i_bit,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [CNT_W-1:0]   i_shift,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [2*WIDTH-1:0] w_row;

   // Gate the row, widen to product width, then shift and accumulate.
   always_comb begin
      w_row = {{WIDTH{1'b0}}, i_mcand & {WIDTH{i_bit}}};
      o_acc = i_acc + (w_row << i_shift);
   end

endmodule

// File: rtl/seq_array_mult.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned, one partial
// product row per clock, valid/ready on both sides.
// Optional: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining
// multiplier magnitude is zero (data-dependent latency, same result).
module seq_array_mult
   import seq_mult_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   m,
   input  logic               sgn,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_p;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mult;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;

   logic [31:0]          w_a_ext;
   logic [31:0]          w_m_ext;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_m_mag;
   logic [WIDTH-1:0]     w_mult_shr;
   logic [2*WIDTH-1:0]   w_acc_nxt;
   logic [2*WIDTH-1:0]   w_p_fix;
   logic                 w_last;

   // Operand magnitudes: sign-extend only in signed mode.
   always_comb begin
      w_a_ext = sgn ? 32'(signed'(a)) : 32'(a);
      w_m_ext = sgn ? 32'(signed'(m)) : 32'(m);
      w_a_mag = WIDTH'(abs_mag(w_a_ext, sgn));
      w_m_mag = WIDTH'(abs_mag(w_m_ext, sgn));
   end

   mult_pp_row #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_row (
      .i_mcand (r_mcand),
      .i_bit   (r_mult[0]),
      .i_acc   (r_acc),
      .i_shift (r_cnt),
      .o_acc   (w_acc_nxt)
   );

   // Last-row detect and sign fix of the final sum.
   always_comb begin
      w_mult_shr = r_mult >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
      w_last     = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mult_shr == '0);
`else
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
`endif
      w_p_fix    = r_neg ? (~w_acc_nxt + (2*WIDTH)'(1)) : w_acc_nxt;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = BUSY;
         BUSY:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, add one row per BUSY edge,
   // capture the signed product on the last row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_p     <= '0;
         r_mcand <= '0;
         r_mult  <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand <= w_a_mag;
                  r_mult  <= w_m_mag;
                  r_neg   <= sgn & (a[WIDTH-1] ^ m[WIDTH-1]);
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_acc  <= w_acc_nxt;
               r_mult <= w_mult_shr;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) r_p <= w_p_fix;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == BUSY);
   assign out_valid = (r_state == DONE);
   assign p         = r_p;

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed and random checks of seq_array_mult at WIDTH=8 and WIDTH=16.
module tb_seq_array_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, sgn, busy;
   logic [7:0]  a, m;
   logic [15:0] p;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, sgn16, busy16;
   logic [15:0] a16, m16;
   logic [31:0] p16;

   int total = 0;
   int bad   = 0;

   seq_array_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .m(m), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
      .p(p), .busy(busy)
   );

   seq_array_mult #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .m(m16), .sgn(sgn16), .out_valid(out_valid16), .out_ready(out_ready16),
      .p(p16), .busy(busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected latency in edges from accept to out_valid.
   function automatic int exp_lat(input int w, input logic [31:0] mm, input logic s);
      logic [31:0] mask, mag;
      int r;
      mask = (32'h1 << w) - 32'h1;
      mag  = (s && mm[w-1]) ? ((~mm + 32'h1) & mask) : (mm & mask);
      r    = 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
      for (int i = 0; i < w; i++) if (mag[i]) r = i + 1;
`else
      r    = w;
`endif
      return r;
   endfunction

   // Drive one operation on the 8-bit DUT; optionally release the result.
   task automatic do_op8(input logic [7:0] ia, input logic [7:0] im, input logic s,
                         input bit rel, output logic [15:0] op, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      a = ia; m = im; sgn = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); m = 8'($urandom); sgn = 1'($urandom);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      op = p;
      if (rel) begin
         out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
      end
   endtask

   task automatic do_op16(input logic [15:0] ia, input logic [15:0] im, input logic s,
                          output logic [31:0] op, output int lat);
      int n;
      n = 0;
      while (!in_ready16 && n < 100) begin @(posedge clk); #1; n++; end
      a16 = ia; m16 = im; sgn16 = s; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (out_valid16) begin lat = i; break; end
      end
      op = p16;
      out_ready16 = 1'b1; @(posedge clk); #1; out_ready16 = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0) begin
         bad++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b p=%h, want 1 0 0 0000",
                  in_ready, out_valid, busy, p);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [7:0]  va [8] = '{8'd105, 8'hFD, 8'h80, 8'hFF, 8'd10, 8'h5A, 8'h00, 8'h7F};
      logic [7:0]  vm [8] = '{8'd125, 8'h05, 8'h80, 8'hFF, 8'h04, 8'h00, 8'h85, 8'h80};
      logic        vs [8] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
      logic [15:0] vp [8] = '{16'h3345, 16'hFFF1, 16'h4000, 16'hFE01,
                              16'h0028, 16'h0000, 16'h0000, 16'hC080};
      logic [15:0] op;
      int lat, el;
      for (int i = 0; i < 8; i++) begin
         do_op8(va[i], vm[i], vs[i], 1'b1, op, lat);
         el = exp_lat(8, 32'(vm[i]), vs[i]);
         total++;
         if (op !== vp[i]) begin
            bad++;
            $display("FAIL directed[%0d] p: got=%h want=%h", i, op, vp[i]);
         end
         total++;
         if (lat != el) begin
            bad++;
            $display("FAIL directed[%0d] latency: got=%0d want=%0d", i, lat, el);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] op;
      int lat;
      do_op8(8'd12, 8'd11, 1'b0, 1'b0, op, lat);
      total++;
      if (op !== 16'h0084) begin
         bad++;
         $display("FAIL bp result: got=%h want=0084", op);
      end
      in_valid = 1'b1; a = 8'd1; m = 8'd1; sgn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || p !== 16'h0084 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp hold[%0d]: out_valid=%b p=%h in_ready=%b want 1 0084 0",
                     i, out_valid, p, in_ready);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 16'h0084) begin
         bad++;
         $display("FAIL bp release: out_valid=%b in_ready=%b p=%h want 0 1 0084",
                  out_valid, in_ready, p);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] op;
      int lat, el;
      a = 8'd200; m = 8'hFF; sgn = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL midop busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'h0) begin
         bad++;
         $display("FAIL midop reset: busy=%b in_ready=%b out_valid=%b p=%h want 0 1 0 0000",
                  busy, in_ready, out_valid, p);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      do_op8(8'd7, 8'd9, 1'b0, 1'b1, op, lat);
      el = exp_lat(8, 32'd9, 1'b0);
      total++;
      if (op !== 16'd63 || lat != el) begin
         bad++;
         $display("FAIL after reset: p=%h lat=%0d want 003f lat=%0d", op, lat, el);
      end
   endtask

   task automatic test_random8();
      logic [7:0]  ra, rm;
      logic        rs;
      logic [15:0] op, ref_p;
      logic signed [15:0] sa, sm;
      int lat, el;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rm = 8'($urandom); rs = 1'($urandom);
         if (rs) begin sa = $signed(ra); sm = $signed(rm); ref_p = 16'(sa * sm); end
         else    ref_p = {8'h0, ra} * {8'h0, rm};
         do_op8(ra, rm, rs, 1'b1, op, lat);
         el = exp_lat(8, 32'(rm), rs);
         total++;
         if (op !== ref_p || lat != el) begin
            bad++;
            $display("FAIL rand8 a=%h m=%h s=%b: p=%h lat=%0d want %h lat=%0d",
                     ra, rm, rs, op, lat, ref_p, el);
         end
      end
   endtask

   task automatic test_random16();
      logic [15:0] ra, rm;
      logic        rs;
      logic [31:0] op, ref_p;
      logic signed [31:0] sa, sm;
      int lat, el;
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rm = 16'($urandom); rs = 1'($urandom);
         if (i == 0) begin ra = 16'h8000; rm = 16'h8000; rs = 1'b1; end
         if (rs) begin sa = $signed(ra); sm = $signed(rm); ref_p = 32'(sa * sm); end
         else    ref_p = {16'h0, ra} * {16'h0, rm};
         do_op16(ra, rm, rs, op, lat);
         el = exp_lat(16, 32'(rm), rs);
         total++;
         if (op !== ref_p || lat != el) begin
            bad++;
            $display("FAIL rand16 a=%h m=%h s=%b: p=%h lat=%0d want %h lat=%0d",
                     ra, rm, rs, op, lat, ref_p, el);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; m = '0; sgn = 1'b0;
      in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; m16 = '0; sgn16 = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_op();
      test_random8();
      test_random16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
